// File: rtl/jtkiwi_shram_pkg.sv
// Shared-RAM arbiter types and helpers: FSM encoding, pointer width, round-robin pick.
// Optional atomic lock support is enabled with JTKIWI_SHRAM_LOCK_EN (see jtkiwi_shram_arb).
package jtkiwi_shram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam int MAXPORTS = 4;

  function automatic int ptrw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] i, input int n);
    return (int'(i) + 1 >= n) ? 2'd0 : i + 2'd1;
  endfunction

  // Returns {found, index} of the first set bit of elig at or after start, wrapping at n.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] start,
                                         input int n);
    logic [2:0] r;
    int         s;
    r = '0;
    for (int k = MAXPORTS - 1; k >= 0; k--) begin
      s = int'(start) + k;
      if (s >= n) s = s - n;
      if (k < n && elig[s[1:0]]) r = {1'b1, s[1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous-read RAM; contents are not touched by reset.
module jtframe_ram #(
  parameter int aw = 13,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          cen,
  input  logic [dw-1:0] data,
  input  logic [aw-1:0] addr,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  always_ff @(posedge clk) begin
    if (cen) begin
      q <= mem[addr];
      if (we) mem[addr] <= data;
    end
  end

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// Round-robin arbiter serialising N CPU ports onto one single-port shared RAM.
// Define JTKIWI_SHRAM_LOCK_EN to let a port hold the grant for atomic read-modify-write.
module jtkiwi_shram_arb
  import jtkiwi_shram_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = 13,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  input  logic [NPORTS-1:0]    lock,
  output logic [NPORTS*DW-1:0] dout,
  output logic [NPORTS-1:0]    ack,
  output logic [NPORTS-1:0]    busy
);

  localparam int PTRW = ptrw(NPORTS);

  state_t            state, state_d;
  logic [PTRW-1:0]   gnt, gnt_d, ptr, ptr_d;
  logic [1:0]        gnt2;
  logic [NPORTS-1:0] ack_d, done;
  logic              we_l;
  logic [3:0]        elig;
  logic [1:0]        start;
  logic [2:0]        pick;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din, ram_q;
  logic              ram_we;

  assign gnt2     = 2'(gnt);
  assign ram_addr = addr[gnt*AW +: AW];
  assign ram_din  = din[gnt*DW +: DW];
  assign ram_we   = (state == ACC) & we[gnt];
  // busy stays up through the ack cycle so the CPU samples dout before resuming
  assign busy     = req & (~done | ack);

`ifdef JTKIWI_SHRAM_LOCK_EN
  logic locked, locked_d;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    ptr_d   = ptr;
    ack_d   = '0;
    elig    = 4'(req & ~done);
    start   = 2'(ptr);
    pick    = '0;
`ifdef JTKIWI_SHRAM_LOCK_EN
    locked_d = locked;
    if (locked) begin
      if (lock[gnt]) elig = elig & (4'd1 << gnt2);
      else begin
        locked_d = 1'b0;
        start    = rr_next(gnt2, NPORTS);
      end
    end
`endif
    case (state)
      IDLE: begin
        pick = rr_pick(elig, start, NPORTS);
        if (pick[2]) begin
          gnt_d   = PTRW'(pick[1:0]);
          state_d = ACC;
        end
      end
      ACC: state_d = RD;
      RD: begin
        ack_d[gnt]  = 1'b1;
        ptr_d       = PTRW'(rr_next(gnt2, NPORTS));
        start       = rr_next(gnt2, NPORTS);
        elig[gnt2]  = 1'b0;
`ifdef JTKIWI_SHRAM_LOCK_EN
        if (lock[gnt]) begin
          locked_d = 1'b1;
          ptr_d    = gnt;
          elig     = '0;
        end else begin
          locked_d = 1'b0;
        end
`endif
        pick = rr_pick(elig, start, NPORTS);
        if (pick[2]) begin
          gnt_d   = PTRW'(pick[1:0]);
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      ack   <= '0;
      done  <= '0;
      dout  <= '0;
      we_l  <= 1'b0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      ptr   <= ptr_d;
      ack   <= ack_d;
      done  <= (done & req) | ack_d;
      if (state == ACC) we_l <= we[gnt];
      if (state == RD && !we_l) dout[gnt*DW +: DW] <= ram_q;
    end
  end

`ifdef JTKIWI_SHRAM_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) locked <= 1'b0;
    else        locked <= locked_d;
  end
`endif

  jtframe_ram #(
    .aw (AW),
    .dw (DW)
  ) u_ram (
    .clk  (clk),
    .cen  (1'b1),
    .data (ram_din),
    .addr (ram_addr),
    .we   (ram_we),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Directed bench for jtkiwi_shram_arb (NPORTS=2); lock steps run when JTKIWI_SHRAM_LOCK_EN is defined.
module tb_jtkiwi_shram_arb;
  import jtkiwi_shram_pkg::*;

  localparam int NP = 2;
  localparam int AW = 13;
  localparam int DW = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     req   = '0;
  logic [NP-1:0]     we    = '0;
  logic [NP-1:0]     lock  = '0;
  logic [NP*AW-1:0]  addr  = '0;
  logic [NP*DW-1:0]  din   = '0;
  logic [NP*DW-1:0]  dout;
  logic [NP-1:0]     ack;
  logic [NP-1:0]     busy;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_ack, cnt_acc;

  always #5 clk = ~clk;

  jtkiwi_shram_arb #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .lock  (lock),
    .dout  (dout),
    .ack   (ack),
    .busy  (busy)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setp(input int p, input logic r, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]           = r;
    we[p]            = w;
    addr[p*AW +: AW] = a;
    din[p*DW +: DW]  = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(3);
    chk("rst_ack",  32'(ack),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_st",   32'(dut.state), 32'(IDLE));
    chk("rst_ptr",  32'(dut.ptr), 32'h0);
    rst_n = 1'b1;
    tick();

    // preload: p0 writes 0x3C @0x0A5
    setp(0, 1'b1, 1'b1, 13'h0A5, 8'h3C);
    tick(3);
    chk("pre_ack", 32'(ack), 32'h1);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // single read: ack at cycle 3, busy drops at cycle 4
    setp(0, 1'b1, 1'b0, 13'h0A5, 8'h0);
    tick(2);
    chk("rd_ack_c2", 32'(ack), 32'h0);
    tick();
    chk("rd_ack_c3",  32'(ack), 32'h1);
    chk("rd_dout0",   32'(dout[7:0]), 32'h3C);
    chk("rd_busy_c3", 32'(busy), 32'h1);
    tick();
    chk("rd_busy_c4", 32'(busy), 32'h0);
    chk("rd_ack_c4",  32'(ack), 32'h0);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // ptr=1: p1 writes 0x5A @0x100 and p0 reads 0x100 in the same cycle
    setp(1, 1'b1, 1'b1, 13'h100, 8'h5A);
    setp(0, 1'b1, 1'b0, 13'h100, 8'h0);
    tick(3);
    chk("wr_ack1", 32'(ack), 32'h2);
    tick(2);
    chk("wr_ack0",  32'(ack), 32'h1);
    chk("wr_dout0", 32'(dout[7:0]), 32'h5A);
    chk("wr_dout1", 32'(dout[15:8]), 32'h00);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    setp(1, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // p1 alone reads 0x0A5, bringing ptr back to 0
    setp(1, 1'b1, 1'b0, 13'h0A5, 8'h0);
    tick(3);
    chk("p1_ack",  32'(ack), 32'h2);
    chk("p1_dout", 32'(dout[15:8]), 32'h3C);
    setp(1, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // tie with ptr=0: p0 first, p1 two cycles later
    setp(0, 1'b1, 1'b0, 13'h0A5, 8'h0);
    setp(1, 1'b1, 1'b0, 13'h100, 8'h0);
    tick(3);
    chk("tie0_ack_c3", 32'(ack), 32'h1);
    chk("tie0_dout0",  32'(dout[7:0]), 32'h3C);
    tick();
    chk("tie0_ack_c4",  32'(ack), 32'h0);
    chk("tie0_busy_c4", 32'(busy), 32'h2);
    tick();
    chk("tie0_ack_c5", 32'(ack), 32'h2);
    chk("tie0_dout1",  32'(dout[15:8]), 32'h5A);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    setp(1, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // p0 alone (ptr -> 1), then a tie goes to p1 first
    setp(0, 1'b1, 1'b0, 13'h100, 8'h0);
    tick(3);
    chk("solo0_dout0", 32'(dout[7:0]), 32'h5A);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();
    setp(0, 1'b1, 1'b0, 13'h100, 8'h0);
    setp(1, 1'b1, 1'b0, 13'h0A5, 8'h0);
    tick(3);
    chk("tie1_ack_c3", 32'(ack), 32'h2);
    chk("tie1_dout1",  32'(dout[15:8]), 32'h3C);
    tick(2);
    chk("tie1_ack_c5", 32'(ack), 32'h1);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    setp(1, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // held request: exactly one access and one ack over 13 cycles
    setp(0, 1'b1, 1'b0, 13'h0A5, 8'h0);
    cnt_ack = 0;
    cnt_acc = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (ack[0]) cnt_ack++;
      if (dut.state == ACC) cnt_acc++;
    end
    chk("held_acks",  32'(cnt_ack), 32'd1);
    chk("held_accs",  32'(cnt_acc), 32'd1);
    chk("held_busy0", 32'(busy), 32'h0);
    chk("held_st",    32'(dut.state), 32'(IDLE));
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

    // reset while in ACC, then p0 retries the read
    setp(0, 1'b1, 1'b0, 13'h0A5, 8'h0);
    tick();
    chk("ra_st_acc", 32'(dut.state), 32'(ACC));
    rst_n = 1'b0;
    tick();
    chk("ra_ack",  32'(ack), 32'h0);
    chk("ra_st",   32'(dut.state), 32'(IDLE));
    chk("ra_ptr",  32'(dut.ptr), 32'h0);
    chk("ra_dout", 32'(dout), 32'h0);
    rst_n = 1'b1;
    tick(2);
    chk("ra_retry_c2", 32'(ack), 32'h0);
    tick();
    chk("ra_retry_ack",  32'(ack), 32'h1);
    chk("ra_retry_dout", 32'(dout[7:0]), 32'h3C);
    setp(0, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();

`ifdef JTKIWI_SHRAM_LOCK_EN
    // p0 locks and does three accesses while p1 waits; p1 follows the unlock
    lock[0] = 1'b1;
    setp(0, 1'b1, 1'b0, 13'h0A5, 8'h0);
    tick();
    setp(1, 1'b1, 1'b0, 13'h100, 8'h0);
    tick(2);
    chk("lk_ack_a", 32'(ack), 32'h1);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick(3);
    chk("lk_ack_b", 32'(ack), 32'h1);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick(3);
    chk("lk_ack_c", 32'(ack), 32'h1);
    req[0]  = 1'b0;
    lock[0] = 1'b0;
    tick(2);
    chk("lk_rel_c2", 32'(ack), 32'h0);
    tick();
    chk("lk_p1_ack",  32'(ack), 32'h2);
    chk("lk_p1_dout", 32'(dout[15:8]), 32'h5A);
    setp(1, 1'b0, 1'b0, 13'h0, 8'h0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
